pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 4: register address width; 2**REG_AW architectural registers.
REQ-002 Parameter DEPTH, default 3: in-flight stages tracked after decode; index 0=EX, 1=MEM, DEPTH-1=WB.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-004 Parameter R0_ZERO, default 1: 1 = register 0 never causes a hazard.
REQ-005 Parameter CNT_W, default 16: stall counter width.
REQ-006 CLK  input  1  single clock; all state updates on rising edge.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 ID_VALID  input  1  decode holds a real instruction.
REQ-009 ID_RS1, ID_RS2  input  REG_AW each  decode source registers.
REQ-010 ID_USE1, ID_USE2  input  1 each  source actually read.
REQ-011 ID_WEN  input  1  instruction writes a register.
REQ-012 ID_RD  input  REG_AW  destination register.
REQ-013 ID_LOAD  input  1  result comes from memory.
REQ-014 HOLD  input  1  global freeze (memory wait); no tracked state changes.
REQ-015 FLUSH  input  1  branch resolved taken; kill decode and EX entry.
REQ-016 STALL_ID  output  1  hold fetch/decode and insert bubble into EX.
REQ-017 FWD1_SEL, FWD2_SEL  output  SW=$clog2(DEPTH+1) each  0=register file, k=stage k-1 result.
REQ-018 INFLIGHT  output  $clog2(DEPTH+1)  count of valid entries with WEN.
REQ-019 STALL_CNT  output  CNT_W  saturating count of stall cycles.

Function
REQ-020 Unit SHALL keep DEPTH entries {V, WEN, RD, LOAD}; each non-HOLD cycle entry k moves to k+1, entry DEPTH-1 retires.
REQ-021 Entry 0 SHALL load decode fields when ID_VALID & !STALL_ID & !FLUSH & !HOLD, else a bubble (V=0).
REQ-022 Match for source s at stage k SHALL be V & WEN & RD==RSs & USEs & !(R0_ZERO & RSs==0).
REQ-023 Entry SHALL be ready at stage k iff !LOAD or k>=1.
REQ-024 FWD_EN=0: STALL_ID SHALL be 1 when any source matches any stage.
REQ-025 FWD_EN=1: per source, youngest (lowest k) match SHALL decide; ready -> FWDs_SEL=k+1, not ready -> STALL_ID=1.
REQ-026 FWDs_SEL SHALL be 0 when no match, when FWD_EN=0, or when ID_VALID=0.
REQ-027 STALL_ID SHALL be 0 when ID_VALID=0 or FLUSH=1; FLUSH wins over any hazard.
REQ-028 FLUSH SHALL clear V of entry 0 at the same edge the shift occurs; stages >=1 unaffected.
REQ-029 HOLD=1 SHALL freeze entries and STALL_CNT; STALL_ID/FWD outputs remain combinational on frozen state.
REQ-030 STALL_CNT SHALL increment on every cycle with STALL_ID=1 & !HOLD, saturating at all-ones.
REQ-031 STALL_ID and FWD selects SHALL be combinational from current entries and decode inputs (zero latency).
REQ-032 Load-use in forwarding mode SHALL cost exactly 1 stall cycle; stall-only mode costs up to DEPTH cycles.

Reset
REQ-033 RST_N low SHALL asynchronously clear all V bits, STALL_CNT=0; hence STALL_ID=0, FWD selects=0, INFLIGHT=0.
REQ-034 Reset asserted mid-stall SHALL drop STALL_ID immediately; first post-reset decode sees empty pipeline.

Structure
REQ-035 Shared package SHALL hold the entry struct {V, WEN, RD, LOAD}, REG_AW default, and FWD select encoding constants (SEL_RF=0).
REQ-036 One sub-module hazard_match SHALL compute per-source youngest match/ready for a single source, instantiated twice.

Verification
REQ-037 FWD_EN=1: ADD r3 then ADD r4,r3,r5 back-to-back -> STALL_ID=0, FWD1_SEL=1.
REQ-038 FWD_EN=1: LW r2 then ADD r6,r2,r1 -> STALL_ID=1 one cycle, next cycle FWD1_SEL=2, STALL_CNT=1.
REQ-039 FWD_EN=0, DEPTH=3: ADD r3 then use r3 -> STALL_ID=1 for 3 cycles, then FWD selects 0.
REQ-040 Writes to r0 then use r0 with R0_ZERO=1 -> no stall, FWD1_SEL=0; R0_ZERO=0 -> FWD1_SEL=1.
REQ-041 Hazard pending, FLUSH=1 -> STALL_ID=0, entry 0 V=0, INFLIGHT decrements as expected.
REQ-042 STALL_CNT preset near 2**CNT_W-1 via repeated stalls, HOLD toggling, RST_N pulse mid-stall -> saturates, freezes under HOLD, clears to 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_hazard_unit_pkg: shared types and constants for the pipeline hazard unit
package pipe_hazard_unit_pkg;
    localparam int REG_AW_DEF = 4;
    localparam int REG_AW_MAX = 8;
    localparam int SEL_RF     = 0;

    // One tracked in-flight instruction; rd is sized for the widest supported register file
    typedef struct packed {
        logic                  v;
        logic                  wen;
        logic [REG_AW_MAX-1:0] rd;
        logic                  load;
    } entry_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: decode-side request and hazard-unit response bundle
interface pipe_hazard_unit_if
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic              id_wen;
    logic [REG_AW-1:0] id_rd;
    logic              id_load;
    logic              hold;
    logic              flush;
    logic              stall_id;
    logic [SW-1:0]     fwd1_sel;
    logic [SW-1:0]     fwd2_sel;
    logic [SW-1:0]     inflight;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_wen, id_rd, id_load, hold, flush,
        input  stall_id, fwd1_sel, fwd2_sel, inflight, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_wen, id_rd, id_load, hold, flush,
        output stall_id, fwd1_sel, fwd2_sel, inflight, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit_hazard_match.sv
// hazard_match: youngest in-flight producer of one source register and whether it can forward
module hazard_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int R0_ZERO = 1,
    parameter int SW      = 2
) (
    input  entry_t [DEPTH-1:0]      ent,
    input  logic [REG_AW_MAX-1:0]   rs,
    input  logic                    use_src,
    output logic                    hit,
    output logic                    ready,
    output logic [SW-1:0]           sel
);
    // Scan oldest to youngest so the youngest matching stage has the last word
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SW'(SEL_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent[k].v && ent[k].wen && ent[k].rd == rs && use_src && !(R0_ZERO != 0 && rs == '0)) begin
                hit   = 1'b1;
                ready = !ent[k].load || k >= 1;
                sel   = SW'(k + 1);
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: tracks in-flight writers, decides decode stall and operand forwarding
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DEPTH   = 3,
    parameter int FWD_EN  = 1,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_unit_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               hit1, hit2, rdy1, rdy2, stall;
    logic [SW-1:0]      sel1, sel2, inflight;

    hazard_match #(.DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .SW(SW)) u_match1 (
        .ent(ent_q), .rs(REG_AW_MAX'(bus.id_rs1)), .use_src(bus.id_use1),
        .hit(hit1), .ready(rdy1), .sel(sel1)
    );

    hazard_match #(.DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .SW(SW)) u_match2 (
        .ent(ent_q), .rs(REG_AW_MAX'(bus.id_rs2)), .use_src(bus.id_use2),
        .hit(hit2), .ready(rdy2), .sel(sel2)
    );

    // Zero-latency stall/forward decision; flush or an empty decode slot never stalls
    always_comb begin
        stall = bus.id_valid && !bus.flush &&
                (FWD_EN != 0 ? (hit1 && !rdy1) || (hit2 && !rdy2) : hit1 || hit2);
        bus.stall_id = stall;
        bus.fwd1_sel = (FWD_EN != 0 && bus.id_valid && hit1 && rdy1) ? sel1 : SW'(SEL_RF);
        bus.fwd2_sel = (FWD_EN != 0 && bus.id_valid && hit2 && rdy2) ? sel2 : SW'(SEL_RF);
        bus.stall_cnt = stall_cnt_q;
    end

    // Count tracked entries that will still write the register file
    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) inflight += SW'(ent_q[k].v && ent_q[k].wen);
        bus.inflight = inflight;
    end

    // Advance the tracker one stage per unfrozen cycle; stalls and flushes inject a bubble
    always_comb begin
        ent_d       = ent_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.hold) begin
            for (int k = DEPTH - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
            ent_d[0] = '0;
            if (bus.id_valid && !stall && !bus.flush)
                ent_d[0] = '{v: 1'b1, wen: bus.id_wen, rd: REG_AW_MAX'(bus.id_rd), load: bus.id_load};
            if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: three configurations (forwarding, stall-only, r0 tracked) against an age-queue model
module tb_pipe_hazard_unit;
    localparam int DEPTH = 3;
    localparam int CW    = 5;
    localparam int CMAX  = 31;

    typedef struct {
        bit v;
        bit wen;
        int rd;
        bit load;
    } ins_t;

    logic       clk, rst_n;
    logic       valid, use1, use2, wen, load, hold, flush;
    logic [3:0] rs1, rs2, rd;

    logic          o_stall [3];
    logic [1:0]    o_s1 [3];
    logic [1:0]    o_s2 [3];
    logic [1:0]    o_inf [3];
    logic [CW-1:0] o_cnt [3];

    ins_t hist [3][$];
    int   m_cnt [3];
    bit   e_stall [3];
    int   e_s1 [3];
    int   e_s2 [3];
    int   e_inf [3];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // g=0: forwarding, g=1: stall-only, g=2: forwarding with r0 tracked like any register
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_unit_if #(.REG_AW(4), .DEPTH(DEPTH), .CNT_W(CW)) bus ();
        assign bus.id_valid = valid;
        assign bus.id_rs1   = rs1;
        assign bus.id_rs2   = rs2;
        assign bus.id_use1  = use1;
        assign bus.id_use2  = use2;
        assign bus.id_wen   = wen;
        assign bus.id_rd    = rd;
        assign bus.id_load  = load;
        assign bus.hold     = hold;
        assign bus.flush    = flush;
        pipe_hazard_unit #(
            .REG_AW(4), .DEPTH(DEPTH), .FWD_EN(g == 1 ? 0 : 1), .R0_ZERO(g == 2 ? 0 : 1), .CNT_W(CW)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus.slave)
        );
        assign o_stall[g] = bus.stall_id;
        assign o_s1[g]    = bus.fwd1_sel;
        assign o_s2[g]    = bus.fwd2_sel;
        assign o_inf[g]   = bus.inflight;
        assign o_cnt[g]   = bus.stall_cnt;
    end

    function automatic void src_look(input int c, input int rs, input bit u,
                                     output bit hit, output bit rdy, output int age);
        hit = 0;
        rdy = 0;
        age = 0;
        if (!u || (c != 2 && rs == 0)) return;
        for (int a = 0; a < hist[c].size(); a++) begin
            if (!hit && hist[c][a].v && hist[c][a].wen && hist[c][a].rd == rs) begin
                hit = 1;
                age = a;
                rdy = !hist[c][a].load || a >= 1;
            end
        end
    endfunction

    function automatic void model_eval();
        for (int c = 0; c < 3; c++) begin
            bit h1, h2, r1, r2, fwd;
            int a1, a2;
            fwd = (c != 1);
            src_look(c, int'(rs1), use1, h1, r1, a1);
            src_look(c, int'(rs2), use2, h2, r2, a2);
            e_stall[c] = valid && !flush && (fwd ? ((h1 && !r1) || (h2 && !r2)) : (h1 || h2));
            e_s1[c] = (fwd && valid && h1 && r1) ? a1 + 1 : 0;
            e_s2[c] = (fwd && valid && h2 && r2) ? a2 + 1 : 0;
            e_inf[c] = 0;
            for (int a = 0; a < hist[c].size(); a++) e_inf[c] += int'(hist[c][a].v && hist[c][a].wen);
        end
    endfunction

    task automatic look();
        #4;
        model_eval();
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        if (!hold) begin
            for (int c = 0; c < 3; c++) begin
                ins_t n;
                n.v    = valid && !e_stall[c] && !flush;
                n.wen  = wen;
                n.rd   = int'(rd);
                n.load = load;
                hist[c].push_front(n);
                if (hist[c].size() > DEPTH) void'(hist[c].pop_back());
                if (e_stall[c] && m_cnt[c] < CMAX) m_cnt[c]++;
            end
        end
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            hist[c].delete();
            m_cnt[c] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_id(input logic v, input int a, input int b, input logic u1, input logic u2,
                          input logic w, input int d, input logic ld);
        valid = v; rs1 = 4'(a); rs2 = 4'(b); use1 = u1; use2 = u2; wen = w; rd = 4'(d); load = ld;
    endtask

    task automatic test_reset();
        set_id(1, 3, 3, 1, 1, 1, 3, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({o_stall[c], o_s1[c], o_s2[c], o_inf[c], o_cnt[c]} !== '0) begin
                errors++;
                $display("FAIL reset c%0d got stall=%0b s1=%0d s2=%0d inf=%0d cnt=%0d want all 0",
                         c, o_stall[c], o_s1[c], o_s2[c], o_inf[c], o_cnt[c]);
            end
        end
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fwd_alu();
        do_reset();
        set_id(1, 1, 2, 1, 1, 1, 3, 0);
        look();
        cyc();
        set_id(1, 3, 5, 1, 1, 1, 4, 0);
        look();
        for (int c = 0; c < 3; c += 2) begin
            checks++;
            if ({o_stall[c], o_s1[c], o_s2[c]} !== {1'b0, 2'd1, 2'd0}) begin
                errors++;
                $display("FAIL fwd_alu c%0d got stall=%0b s1=%0d s2=%0d want 0 1 0", c, o_stall[c], o_s1[c], o_s2[c]);
            end
        end
        checks++;
        if ({o_stall[1], o_s1[1]} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL stall_only_first got stall=%0b s1=%0d want 1 0", o_stall[1], o_s1[1]);
        end
    endtask

    task automatic test_stall_only();
        for (int i = 0; i < 3; i++) begin
            cyc();
            look();
            checks++;
            if ({o_stall[1], o_s1[1], o_s2[1]} !== {i < 2, 2'd0, 2'd0}) begin
                errors++;
                $display("FAIL stall_only step%0d got stall=%0b s1=%0d s2=%0d want %0b 0 0",
                         i, o_stall[1], o_s1[1], o_s2[1], i < 2);
            end
        end
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 2, 1);
        look();
        cyc();
        set_id(1, 2, 1, 1, 1, 1, 6, 0);
        look();
        checks++;
        if ({o_stall[0], o_cnt[0]} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL load_use_stall got stall=%0b cnt=%0d want 1 0", o_stall[0], o_cnt[0]);
        end
        cyc();
        look();
        checks++;
        if ({o_stall[0], o_s1[0], o_s2[0], o_cnt[0]} !== {1'b0, 2'd2, 2'd0, 5'd1}) begin
            errors++;
            $display("FAIL load_use_fwd got stall=%0b s1=%0d s2=%0d cnt=%0d want 0 2 0 1",
                     o_stall[0], o_s1[0], o_s2[0], o_cnt[0]);
        end
        cyc();
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1, 1, 1, 0, 0, 1, 0, 0);
        look();
        cyc();
        set_id(1, 0, 7, 1, 0, 1, 5, 0);
        look();
        checks++;
        if ({o_stall[0], o_s1[0], o_stall[1]} !== {1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL r0_zero got stall=%0b s1=%0d stall_only=%0b want 0 0 0", o_stall[0], o_s1[0], o_stall[1]);
        end
        checks++;
        if ({o_stall[2], o_s1[2]} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL r0_tracked got stall=%0b s1=%0d want 0 1", o_stall[2], o_s1[2]);
        end
        cyc();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 3, 0);
        look();
        cyc();
        set_id(1, 0, 0, 0, 0, 1, 5, 1);
        look();
        cyc();
        set_id(1, 3, 5, 1, 1, 1, 7, 0);
        flush = 1'b1;
        look();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({o_stall[c], o_inf[c]} !== {1'b0, 2'd2}) begin
                errors++;
                $display("FAIL flush_stall c%0d got stall=%0b inf=%0d want 0 2", c, o_stall[c], o_inf[c]);
            end
        end
        cyc();
        set_id(1, 0, 0, 0, 0, 1, 9, 0);
        look();
        checks++;
        if (o_inf[0] !== 2'd2) begin
            errors++;
            $display("FAIL flush_inf1 got inf=%0d want 2", o_inf[0]);
        end
        cyc();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        look();
        checks++;
        if (o_inf[0] !== 2'd1) begin
            errors++;
            $display("FAIL flush_inf2 got inf=%0d want 1", o_inf[0]);
        end
        cyc();
        look();
        checks++;
        if (o_inf[0] !== 2'd0) begin
            errors++;
            $display("FAIL flush_inf3 got inf=%0d want 0", o_inf[0]);
        end
        cyc();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_id(1, 0, 0, 0, 0, 1, 2, 1);
            look();
            cyc();
            set_id(1, 2, 0, 1, 0, 1, 6, 0);
            look();
            cyc();
            if (i == 29) begin
                checks++;
                if (o_cnt[0] !== 5'd30) begin
                    errors++;
                    $display("FAIL sat_mid got cnt=%0d want 30", o_cnt[0]);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_cnt[c] !== 5'd31) begin
                errors++;
                $display("FAIL sat_top c%0d got cnt=%0d want 31", c, o_cnt[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        set_id(1, 0, 0, 0, 0, 1, 2, 1);
        look();
        cyc();
        set_id(1, 2, 0, 1, 0, 1, 6, 0);
        look();
        checks++;
        if (o_stall[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall got stall=%0b want 1", o_stall[0]);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({o_stall[c], o_inf[c], o_cnt[c]} !== '0) begin
                errors++;
                $display("FAIL async_reset c%0d got stall=%0b inf=%0d cnt=%0d want 0 0 0", c, o_stall[c], o_inf[c], o_cnt[c]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        look();
        checks++;
        if ({o_stall[0], o_s1[0]} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL post_reset got stall=%0b s1=%0d want 0 0", o_stall[0], o_s1[0]);
        end
        cyc();
    endtask

    task automatic test_hold();
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 2, 1);
        look();
        cyc();
        set_id(1, 2, 0, 1, 0, 1, 6, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            checks++;
            if ({o_stall[0], o_cnt[0], o_inf[0]} !== {1'b1, 5'd0, 2'd1}) begin
                errors++;
                $display("FAIL hold%0d got stall=%0b cnt=%0d inf=%0d want 1 0 1", i, o_stall[0], o_cnt[0], o_inf[0]);
            end
            cyc();
        end
        hold = 1'b0;
        look();
        cyc();
        look();
        checks++;
        if ({o_stall[0], o_s1[0], o_cnt[0]} !== {1'b0, 2'd2, 5'd1}) begin
            errors++;
            $display("FAIL hold_release got stall=%0b s1=%0d cnt=%0d want 0 2 1", o_stall[0], o_s1[0], o_cnt[0]);
        end
        cyc();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 9) < 3);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            look();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (o_stall[c] !== e_stall[c] || o_s1[c] !== 2'(e_s1[c]) || o_s2[c] !== 2'(e_s2[c]) ||
                    o_inf[c] !== 2'(e_inf[c]) || o_cnt[c] !== CW'(m_cnt[c])) begin
                    errors++;
                    $display("FAIL random i%0d c%0d got stall=%0b s1=%0d s2=%0d inf=%0d cnt=%0d want %0b %0d %0d %0d %0d",
                             i, c, o_stall[c], o_s1[c], o_s2[c], o_inf[c], o_cnt[c],
                             e_stall[c], e_s1[c], e_s2[c], e_inf[c], m_cnt[c]);
                end
            end
            cyc();
        end
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        test_reset();
        test_fwd_alu();
        test_stall_only();
        test_load_use();
        test_r0();
        test_flush();
        test_saturate();
        test_async_reset();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
